run_ctrl: RTL and testbench
===========================

# run_ctrl

Program-run sequencer between the test harness and the processor core. It accepts a `req`/`done` four-phase handshake and latches one of four program slots. It holds the core in reset while it drives the slot's start address, then enables the core and waits for the core's completion flag. It also counts execution cycles and aborts runaway programs with a watchdog timeout.

## Interface
- D, 12, program counter width; width of `start_addr`
- CW, 16, cycle counter width
- RST_CYC, 2, cycles `core_rst` is held in LOAD (minimum 1)
- TIMEOUT, 4096, maximum RUN cycles before abort (must be at most 2^CW − 1)
- BASE0, 0, start address of program slot 0 (D bits)
- BASE1, 128, start address of slot 1
- BASE2, 256, start address of slot 2
- BASE3, 384, start address of slot 3

Ports:
- clk  in  1  single clock; all logic is updated on the rising edge
- reset  in  1  synchronous, active-low; the block resets when reset = 0 at a rising edge
- req  in  1  run request, level, four-phase handshake
- prog_sel  in  2  program slot, sampled only when req is accepted
- core_done  in  1  completion flag from the core (its `done`)
- core_rst  out  1  reset to the core, active-high
- core_en  out  1  enable for the core's PC and register writes
- start_addr  out  D  PC reset/load value for the selected slot
- busy  out  1  high in LOAD and RUN
- done  out  1  run complete, held until req drops
- timeout  out  1  qualifies `done`: the run was aborted by the watchdog
- cycles  out  CW  RUN-cycle count of the last or current run

## Operation
- States: IDLE, LOAD, RUN, FIN. All outputs are registered.
- Reset (reset = 0) forces the following, regardless of state:
  - state = IDLE, core_rst = 1, core_en = 0, start_addr = BASE0
  - busy = 0, done = 0, timeout = 0, cycles = 0, load counter = 0
- IDLE:
  - core_rst = 1, core_en = 0.
  - If req = 1, latch prog_sel, load start_addr with BASE[prog_sel], clear cycles and timeout, and go to LOAD.
- LOAD:
  - core_rst = 1 for exactly RST_CYC cycles; start_addr is stable.
  - Then go to RUN with core_rst = 0 and core_en = 1.
  - core_done is ignored in LOAD, because the core's flag is stale while it is in reset.
- RUN:
  - core_en = 1; cycles increments by 1 every RUN cycle and saturates at 2^CW − 1.
  - On core_done = 1: go to FIN with timeout = 0. The cycle that samples core_done is counted.
  - If no core_done arrives and cycles reaches TIMEOUT: go to FIN with timeout = 1.
  - If core_done = 1 arrives in the same cycle the count reaches TIMEOUT, core_done wins and timeout = 0.
- FIN:
  - core_en = 0 and core_rst = 0, so the core state stays readable; done = 1 and cycles is frozen.
  - When req = 0, go to IDLE with done = 0. timeout and cycles keep their values until the next accept.
- req deasserted during LOAD or RUN is ignored; the run completes. A new request is accepted only after FIN → IDLE.
- prog_sel changes outside the accept cycle have no effect.
- Reset asserted mid-run aborts the run immediately. done is not produced.

## Timing
- Accept: with req = 1 sampled at edge N in IDLE:
  - busy = 1, core_rst = 1 and start_addr are valid after edge N.
  - core_en = 1 and core_rst = 0 after edge N + RST_CYC.
- Completion: core_done = 1 sampled at edge M in RUN gives done = 1 and busy = 0 after edge M, a one-cycle latency.
- Handshake release: req = 0 sampled at edge K in FIN gives done = 0 after edge K. If req = 1 at edge K + 1, the next accept happens at K + 1, so the minimum gap is one IDLE cycle.
- Watchdog: the abort happens at the edge where cycles becomes TIMEOUT. cycles reads TIMEOUT in FIN.
- The shortest run has RUN lasting 1 cycle, with core_done already high at the first RUN edge; then cycles = 1.

## Test plan
- Reset and idle: hold reset = 0 for 3 cycles with req = 1. Required: core_rst = 1, core_en = 0, busy = 0, done = 0, cycles = 0, start_addr = 0, and no accept while reset = 0.
- Basic run: prog_sel = 2, req = 1; the core model raises core_done after 37 RUN cycles. Required:
  - start_addr = 256
  - core_rst high for exactly 2 cycles
  - done = 1, timeout = 0, cycles = 37
  - done drops one cycle after req = 0
- Watchdog: TIMEOUT = 100 and core_done is never raised. Required: FIN after 100 RUN cycles, done = 1, timeout = 1, cycles = 100, core_en = 0.
- Tie and stale flag:
  - core_done = 1 throughout LOAD must not end the run; RUN must last at least 1 cycle, giving cycles = 1.
  - With TIMEOUT = 10 and core_done first raised on the 10th RUN cycle: timeout = 0, cycles = 10.
- Handshake abuse:
  - Drop req mid-RUN; the run must still complete with done = 1.
  - Change prog_sel = 3 mid-RUN; start_addr stays 256.
  - Hold req = 1 in FIN; done stays 1 indefinitely.
- Back-to-back runs with reset mid-operation:
  - Run slot 1, release, then immediately request slot 3; start_addr = 384 and cycles restarts from 0.
  - Assert reset = 0 on RUN cycle 5; the next edge gives IDLE, core_rst = 1, cycles = 0.

Source files
------------

// File: rtl/run_ctrl_if.sv
// Handshake and core-control bundle between the test harness, run_ctrl and the core.
// The master side is the harness plus the core's done flag; the slave side is run_ctrl.
interface run_ctrl_if #(
   parameter int D  = 12,
   parameter int CW = 16
);
   logic          req;
   logic [1:0]    prog_sel;
   logic          core_done;
   logic          core_rst;
   logic          core_en;
   logic [D-1:0]  start_addr;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [CW-1:0] cycles;

   modport master (
      output req, prog_sel, core_done,
      input  core_rst, core_en, start_addr, busy, done, timeout, cycles
   );

   modport slave (
      input  req, prog_sel, core_done,
      output core_rst, core_en, start_addr, busy, done, timeout, cycles
   );
endinterface

// File: rtl/run_ctrl.sv
// Program-run sequencer: four-phase req/done handshake, core reset/enable sequencing,
// RUN-cycle counting and a watchdog that aborts runaway programs.
//
// state  | meaning
// IDLE   | core held in reset, waiting for req
// LOAD   | core held in reset for RST_CYC cycles while start_addr settles
// RUN    | core enabled, counting cycles, waiting for core_done or watchdog
// FIN    | core frozen (not in reset), done high until req drops
module run_ctrl #(
   parameter int          D       = 12,
   parameter int          CW      = 16,
   parameter int          RST_CYC = 2,
   parameter int          TIMEOUT = 4096,
   parameter logic [D-1:0] BASE0  = D'(0),
   parameter logic [D-1:0] BASE1  = D'(128),
   parameter logic [D-1:0] BASE2  = D'(256),
   parameter logic [D-1:0] BASE3  = D'(384)
) (
   input logic       clk,
   input logic       reset,
   run_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   localparam int             LW        = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [LW-1:0]  LOAD_INIT = LW'(RST_CYC - 1);
   localparam logic [CW-1:0]  CYC_MAX   = {CW{1'b1}};
   localparam logic [CW-1:0]  TIMEOUT_C = CW'(TIMEOUT);

   logic [1:0]    state_q, state_d;
   logic [LW-1:0] load_cnt_q, load_cnt_d;
   logic          core_rst_q, core_rst_d;
   logic          core_en_q, core_en_d;
   logic [D-1:0]  start_addr_q, start_addr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          timeout_q, timeout_d;
   logic [CW-1:0] cycles_q, cycles_d;

   logic [D-1:0]  base_addr;
   logic [CW-1:0] cyc_inc;

   always_comb begin
      base_addr = BASE0;
      case (bus.prog_sel)
         2'd0:    base_addr = BASE0;
         2'd1:    base_addr = BASE1;
         2'd2:    base_addr = BASE2;
         default: base_addr = BASE3;
      endcase
   end

   assign cyc_inc = (cycles_q == CYC_MAX) ? cycles_q : cycles_q + CW'(1);

   always_comb begin
      state_d      = state_q;
      load_cnt_d   = load_cnt_q;
      core_rst_d   = core_rst_q;
      core_en_d    = core_en_q;
      start_addr_d = start_addr_q;
      busy_d       = busy_q;
      done_d       = done_q;
      timeout_d    = timeout_q;
      cycles_d     = cycles_q;

      case (state_q)
         S_IDLE: begin
            core_rst_d = 1'b1;
            core_en_d  = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            if (bus.req) begin
               state_d      = S_LOAD;
               start_addr_d = base_addr;
               cycles_d     = '0;
               timeout_d    = 1'b0;
               load_cnt_d   = LOAD_INIT;
               busy_d       = 1'b1;
            end
         end

         // core_done is stale while the core is in reset, so LOAD never looks at it
         S_LOAD: begin
            if (load_cnt_q == '0) begin
               state_d    = S_RUN;
               core_rst_d = 1'b0;
               core_en_d  = 1'b1;
            end else begin
               load_cnt_d = load_cnt_q - LW'(1);
            end
         end

         // the cycle that samples core_done is counted, and core_done beats the watchdog
         S_RUN: begin
            cycles_d = cyc_inc;
            if (bus.core_done || (cyc_inc == TIMEOUT_C)) begin
               state_d   = S_FIN;
               timeout_d = !bus.core_done;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               core_en_d = 1'b0;
            end
         end

         S_FIN: begin
            if (!bus.req) begin
               state_d    = S_IDLE;
               done_d     = 1'b0;
               core_rst_d = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         load_cnt_q   <= '0;
         core_rst_q   <= 1'b1;
         core_en_q    <= 1'b0;
         start_addr_q <= BASE0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         cycles_q     <= '0;
      end else begin
         state_q      <= state_d;
         load_cnt_q   <= load_cnt_d;
         core_rst_q   <= core_rst_d;
         core_en_q    <= core_en_d;
         start_addr_q <= start_addr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         cycles_q     <= cycles_d;
      end
   end

   assign bus.core_rst   = core_rst_q;
   assign bus.core_en    = core_en_q;
   assign bus.start_addr = start_addr_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.timeout    = timeout_q;
   assign bus.cycles     = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: two instances, watchdog at 100 (main) and 10 (tie case).
module tb_run_ctrl;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   run_ctrl_if #(.D(12), .CW(16)) bus_a ();
   run_ctrl_if #(.D(12), .CW(16)) bus_b ();

   run_ctrl #(.D(12), .CW(16), .RST_CYC(2), .TIMEOUT(100)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a.slave)
   );
   run_ctrl #(.D(12), .CW(16), .RST_CYC(2), .TIMEOUT(10)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus_a.req = 1'b1;
      bus_a.prog_sel = 2'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus_a.busy !== 1'b0) begin $display("FAIL reset_busy: got %0b want 0", bus_a.busy); errors++; end
      end
      checks++; if (bus_a.core_rst !== 1'b1) begin $display("FAIL reset_core_rst: got %0b want 1", bus_a.core_rst); errors++; end
      checks++; if (bus_a.core_en !== 1'b0) begin $display("FAIL reset_core_en: got %0b want 0", bus_a.core_en); errors++; end
      checks++; if (bus_a.done !== 1'b0) begin $display("FAIL reset_done: got %0b want 0", bus_a.done); errors++; end
      checks++; if (bus_a.cycles !== 16'd0) begin $display("FAIL reset_cycles: got %0d want 0", bus_a.cycles); errors++; end
      checks++; if (bus_a.start_addr !== 12'd0) begin $display("FAIL reset_start_addr: got %0d want 0", bus_a.start_addr); errors++; end
      checks++; if (bus_a.timeout !== 1'b0) begin $display("FAIL reset_timeout: got %0b want 0", bus_a.timeout); errors++; end
      bus_a.req = 1'b0;
      reset = 1'b1;
      tick();
      checks++; if (bus_a.busy !== 1'b0) begin $display("FAIL idle_busy: got %0b want 0", bus_a.busy); errors++; end
   endtask

   task automatic test_basic_run();
      int rst_cnt;
      bus_a.prog_sel = 2'd2;
      bus_a.req = 1'b1;
      tick();
      checks++; if (bus_a.busy !== 1'b1) begin $display("FAIL basic_busy: got %0b want 1", bus_a.busy); errors++; end
      checks++; if (bus_a.start_addr !== 12'd256) begin $display("FAIL basic_start_addr: got %0d want 256", bus_a.start_addr); errors++; end
      rst_cnt = 0;
      while (bus_a.core_rst === 1'b1 && rst_cnt < 10) begin
         rst_cnt++;
         tick();
      end
      checks++; if (rst_cnt !== 2) begin $display("FAIL basic_rst_len: got %0d want 2", rst_cnt); errors++; end
      checks++; if (bus_a.core_en !== 1'b1) begin $display("FAIL basic_core_en: got %0b want 1", bus_a.core_en); errors++; end
      for (int i = 0; i < 36; i++) tick();
      checks++; if (bus_a.cycles !== 16'd36 || bus_a.done !== 1'b0) begin $display("FAIL basic_mid: got cycles %0d done %0b want 36 0", bus_a.cycles, bus_a.done); errors++; end
      bus_a.core_done = 1'b1;
      tick();
      bus_a.core_done = 1'b0;
      checks++; if (bus_a.done !== 1'b1) begin $display("FAIL basic_done: got %0b want 1", bus_a.done); errors++; end
      checks++; if (bus_a.busy !== 1'b0) begin $display("FAIL basic_fin_busy: got %0b want 0", bus_a.busy); errors++; end
      checks++; if (bus_a.timeout !== 1'b0) begin $display("FAIL basic_timeout: got %0b want 0", bus_a.timeout); errors++; end
      checks++; if (bus_a.cycles !== 16'd37) begin $display("FAIL basic_cycles: got %0d want 37", bus_a.cycles); errors++; end
      checks++; if (bus_a.core_en !== 1'b0 || bus_a.core_rst !== 1'b0) begin $display("FAIL basic_fin_core: got en %0b rst %0b want 0 0", bus_a.core_en, bus_a.core_rst); errors++; end
      bus_a.req = 1'b0;
      tick();
      checks++; if (bus_a.done !== 1'b0) begin $display("FAIL basic_release: got %0b want 0", bus_a.done); errors++; end
      checks++; if (bus_a.cycles !== 16'd37) begin $display("FAIL basic_cycles_kept: got %0d want 37", bus_a.cycles); errors++; end
   endtask

   task automatic test_watchdog();
      int n;
      bus_a.prog_sel = 2'd0;
      bus_a.req = 1'b1;
      tick();
      tick();
      tick();
      n = 0;
      while (bus_a.done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++; if (n !== 100) begin $display("FAIL wd_run_len: got %0d want 100", n); errors++; end
      checks++; if (bus_a.done !== 1'b1 || bus_a.timeout !== 1'b1) begin $display("FAIL wd_flags: got done %0b timeout %0b want 1 1", bus_a.done, bus_a.timeout); errors++; end
      checks++; if (bus_a.cycles !== 16'd100) begin $display("FAIL wd_cycles: got %0d want 100", bus_a.cycles); errors++; end
      checks++; if (bus_a.core_en !== 1'b0) begin $display("FAIL wd_core_en: got %0b want 0", bus_a.core_en); errors++; end
      bus_a.req = 1'b0;
      tick();
      checks++; if (bus_a.timeout !== 1'b1 || bus_a.cycles !== 16'd100 || bus_a.done !== 1'b0) begin $display("FAIL wd_after: got timeout %0b cycles %0d done %0b want 1 100 0", bus_a.timeout, bus_a.cycles, bus_a.done); errors++; end
   endtask

   task automatic test_tie_stale();
      bus_a.core_done = 1'b1;
      bus_a.prog_sel = 2'd1;
      bus_a.req = 1'b1;
      tick();
      tick();
      tick();
      checks++; if (bus_a.done !== 1'b0 || bus_a.core_en !== 1'b1) begin $display("FAIL stale_load: got done %0b en %0b want 0 1", bus_a.done, bus_a.core_en); errors++; end
      tick();
      bus_a.core_done = 1'b0;
      bus_a.req = 1'b0;
      checks++; if (bus_a.done !== 1'b1 || bus_a.cycles !== 16'd1 || bus_a.timeout !== 1'b0) begin $display("FAIL stale_short: got done %0b cycles %0d timeout %0b want 1 1 0", bus_a.done, bus_a.cycles, bus_a.timeout); errors++; end
      tick();

      bus_b.prog_sel = 2'd0;
      bus_b.req = 1'b1;
      tick();
      tick();
      tick();
      for (int i = 0; i < 9; i++) tick();
      checks++; if (bus_b.done !== 1'b0 || bus_b.cycles !== 16'd9) begin $display("FAIL tie_pre: got done %0b cycles %0d want 0 9", bus_b.done, bus_b.cycles); errors++; end
      bus_b.core_done = 1'b1;
      tick();
      bus_b.core_done = 1'b0;
      bus_b.req = 1'b0;
      checks++; if (bus_b.done !== 1'b1 || bus_b.timeout !== 1'b0 || bus_b.cycles !== 16'd10) begin $display("FAIL tie_result: got done %0b timeout %0b cycles %0d want 1 0 10", bus_b.done, bus_b.timeout, bus_b.cycles); errors++; end
      tick();
   endtask

   task automatic test_handshake_abuse();
      int held_bad;
      bus_a.prog_sel = 2'd2;
      bus_a.req = 1'b1;
      tick();
      tick();
      tick();
      for (int i = 0; i < 5; i++) tick();
      bus_a.req = 1'b0;
      bus_a.prog_sel = 2'd3;
      for (int i = 0; i < 5; i++) tick();
      checks++; if (bus_a.start_addr !== 12'd256 || bus_a.busy !== 1'b1) begin $display("FAIL abuse_addr: got addr %0d busy %0b want 256 1", bus_a.start_addr, bus_a.busy); errors++; end
      bus_a.core_done = 1'b1;
      tick();
      bus_a.core_done = 1'b0;
      checks++; if (bus_a.done !== 1'b1 || bus_a.cycles !== 16'd11) begin $display("FAIL abuse_done: got done %0b cycles %0d want 1 11", bus_a.done, bus_a.cycles); errors++; end
      tick();
      checks++; if (bus_a.done !== 1'b0) begin $display("FAIL abuse_release: got %0b want 0", bus_a.done); errors++; end

      bus_a.prog_sel = 2'd0;
      bus_a.req = 1'b1;
      tick();
      tick();
      tick();
      bus_a.core_done = 1'b1;
      tick();
      bus_a.core_done = 1'b0;
      held_bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus_a.done !== 1'b1) held_bad++;
         tick();
      end
      checks++; if (held_bad !== 0) begin $display("FAIL abuse_hold: got %0d cycles without done want 0", held_bad); errors++; end
      bus_a.req = 1'b0;
      tick();
      checks++; if (bus_a.done !== 1'b0) begin $display("FAIL abuse_hold_release: got %0b want 0", bus_a.done); errors++; end
   endtask

   task automatic test_back_to_back();
      bus_a.prog_sel = 2'd1;
      bus_a.req = 1'b1;
      tick();
      checks++; if (bus_a.start_addr !== 12'd128) begin $display("FAIL b2b_addr1: got %0d want 128", bus_a.start_addr); errors++; end
      tick();
      tick();
      for (int i = 0; i < 3; i++) tick();
      bus_a.core_done = 1'b1;
      tick();
      bus_a.core_done = 1'b0;
      checks++; if (bus_a.done !== 1'b1 || bus_a.cycles !== 16'd4) begin $display("FAIL b2b_run1: got done %0b cycles %0d want 1 4", bus_a.done, bus_a.cycles); errors++; end
      bus_a.req = 1'b0;
      tick();
      bus_a.req = 1'b1;
      bus_a.prog_sel = 2'd3;
      tick();
      checks++; if (bus_a.busy !== 1'b1 || bus_a.start_addr !== 12'd384 || bus_a.cycles !== 16'd0) begin $display("FAIL b2b_accept2: got busy %0b addr %0d cycles %0d want 1 384 0", bus_a.busy, bus_a.start_addr, bus_a.cycles); errors++; end
      tick();
      tick();
      for (int i = 0; i < 4; i++) tick();
      checks++; if (bus_a.cycles !== 16'd4 || bus_a.core_en !== 1'b1) begin $display("FAIL b2b_run2: got cycles %0d en %0b want 4 1", bus_a.cycles, bus_a.core_en); errors++; end
      reset = 1'b0;
      tick();
      checks++; if (bus_a.busy !== 1'b0 || bus_a.core_rst !== 1'b1 || bus_a.cycles !== 16'd0 || bus_a.core_en !== 1'b0 || bus_a.done !== 1'b0 || bus_a.start_addr !== 12'd0) begin
         $display("FAIL b2b_reset: got busy %0b rst %0b cycles %0d en %0b done %0b addr %0d want 0 1 0 0 0 0", bus_a.busy, bus_a.core_rst, bus_a.cycles, bus_a.core_en, bus_a.done, bus_a.start_addr); errors++;
      end
      reset = 1'b1;
      bus_a.req = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      checks++; if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) begin $display("FAIL b2b_no_done: got done %0b busy %0b want 0 0", bus_a.done, bus_a.busy); errors++; end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      bus_a.req = 1'b0;
      bus_a.prog_sel = 2'd0;
      bus_a.core_done = 1'b0;
      bus_b.req = 1'b0;
      bus_b.prog_sel = 2'd0;
      bus_b.core_done = 1'b0;
      test_reset();
      test_basic_run();
      test_watchdog();
      test_tie_stale();
      test_handshake_abuse();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
